fft_stage_sequencer: RTL and testbench

Frame-level controller for the iterative FFT datapath: serial-to-parallel buffer -> input mux -> butterfly -> demux -> feedback register or parallel-to-serial output.
- Accepts a loaded frame from the serial-to-parallel buffer and runs STAGES passes of BEATS beats each through the single butterfly.
- Per beat, drives the input-mux select and the twiddle rotation index.
- Drives demux routing, delayed to match butterfly latency, so results go to the feedback register or, on the final stage, to the output serializer.

---
 rtl/fft_stage_sequencer_pkg.sv | 25 ++
 rtl/fft_flag_delay.sv | 38 +++
 rtl/fft_stage_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stage_sequencer_pkg.sv
// rtl/fft_stage_sequencer_pkg.sv - shared encodings for the FFT stage sequencer
// Purpose: state encoding, mux/demux select values and datapath widths
//          shared by the sequencer and its datapath neighbours.
package fft_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_PS_WAIT = 2'd3
  } seq_state_e;

  // Butterfly input mux select
  localparam logic MUX_SP   = 1'b0;
  localparam logic MUX_FB   = 1'b1;

  // Butterfly output demux select
  localparam logic DEMUX_FB = 1'b0;
  localparam logic DEMUX_PS = 1'b1;

  // Datapath widths: one beat carries 4 complex samples
  localparam int BEAT_W   = 136;
  localparam int SAMPLE_W = 34;

endpackage

// File: rtl/fft_flag_delay.sv
// rtl/fft_flag_delay.sv - DEPTH-stage shift register aligning issue flags to butterfly output
// Ports:
//   clk  - clock, rising edge
//   clr  - synchronous clear of every stage
//   din  - flags entering at issue time
//   dout - flags DEPTH cycles later
module fft_flag_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;
  logic [DEPTH-1:0][WIDTH-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - frame-level controller for the iterative FFT butterfly datapath
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   sp_frame_rdy  - frame available from serial-to-parallel buffer (pulse)
//   ps_ready      - serializer can take a full frame
//   sp_ack        - frame taken (pulse, cycle after acceptance)
//   mux_flag      - butterfly input select (buffer / feedback)
//   bf_en         - beat valid into butterfly
//   rotation      - twiddle index of the current beat
//   demux_flag    - butterfly output routing, latency-aligned
//   fb_we         - feedback register write, latency-aligned
//   ps_valid      - serializer beat valid, latency-aligned
//   frame_done    - final output beat of the frame
//   busy          - sequencer not idle
//   err_overrun   - sticky: frame offered while busy
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int BEATS  = 2,
  parameter int BF_LAT = 1,
  parameter int ROT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sp_frame_rdy,
  input  logic             ps_ready,
  output logic             sp_ack,
  output logic             mux_flag,
  output logic             bf_en,
  output logic [ROT_W-1:0] rotation,
  output logic             demux_flag,
  output logic             fb_we,
  output logic             ps_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             err_overrun
);

  localparam int BW = (BEATS  > 1) ? $clog2(BEATS)  : 1;
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(BF_LAT - 1);

  seq_state_e    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          sp_ack_q, sp_ack_d;
  logic          err_q, err_d;

  logic          is_last_stage;
  logic [1:0]    flags_out;
  logic          dly_en;
  logic          dly_last;

  assign is_last_stage = (stage_q == STAGE_LAST);

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    stage_d  = stage_q;
    drain_d  = drain_q;
    sp_ack_d = 1'b0;
    // Only a frame sampled in IDLE is accepted; anything else is an overrun.
    err_d    = err_q | (sp_frame_rdy && (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (sp_frame_rdy) begin
          sp_ack_d = 1'b1;
          beat_d   = '0;
          stage_d  = '0;
          drain_d  = '0;
          // A single-stage frame goes straight to the serializer.
          if ((STAGES == 1) && !ps_ready) begin
            state_d = ST_PS_WAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (beat_q == BEAT_LAST) begin
          beat_d  = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          if (is_last_stage) begin
            stage_d = '0;
            state_d = ST_IDLE;
          end else begin
            stage_d = stage_q + SW'(1);
            // ps_ready is only looked at on entry to the last stage.
            if ((stage_q + SW'(1) == STAGE_LAST) && !ps_ready) begin
              state_d = ST_PS_WAIT;
            end else begin
              state_d = ST_RUN;
            end
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_PS_WAIT: begin
        if (ps_ready) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      stage_q  <= '0;
      drain_q  <= '0;
      sp_ack_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      stage_q  <= stage_d;
      drain_q  <= drain_d;
      sp_ack_q <= sp_ack_d;
      err_q    <= err_d;
    end
  end

  assign bf_en       = (state_q == ST_RUN);
  assign busy        = (state_q != ST_IDLE);
  assign sp_ack      = sp_ack_q;
  assign err_overrun = err_q;

  // stage_q only advances on leaving DRAIN, so the select naturally holds
  // its last value between issue windows.
  assign mux_flag = (stage_q == '0) ? MUX_SP : MUX_FB;

  // Twiddle step doubles each stage: beat_idx << stage_idx.
  assign rotation = bf_en ? (ROT_W'(beat_q) << stage_q) : '0;

  fft_flag_delay #(
    .DEPTH (BF_LAT),
    .WIDTH (2)
  ) u_flag_delay (
    .clk  (clk),
    .clr  (rst),
    .din  ({is_last_stage, bf_en}),
    .dout (flags_out)
  );

  assign dly_last   = flags_out[1];
  assign dly_en     = flags_out[0];
  assign demux_flag = dly_last ? DEMUX_PS : DEMUX_FB;
  assign ps_valid   = dly_en & dly_last;
  assign fb_we      = dly_en & ~dly_last;

  // The last beat of the last stage emerges in the final DRAIN cycle.
  assign frame_done = ps_valid && (state_q == ST_DRAIN) &&
                      (drain_q == DRAIN_LAST) && is_last_stage;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - scoreboard bench for fft_stage_sequencer (BF_LAT 1 and 3)
module tb_fft_stage_sequencer;

  typedef struct {
    int         cyc;
    logic       bf_en;
    logic [2:0] rot;
    logic       mux;
    logic       fb_we;
    logic       ps_valid;
    logic       frame_done;
    logic       busy;
    logic       sp_ack;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic       a_rdy = 1'b0, a_psr = 1'b1;
  logic       a_ack, a_mux, a_en, a_demux, a_fbwe, a_psv, a_done, a_busy, a_err;
  logic [2:0] a_rot;
  logic       b_rdy = 1'b0, b_psr = 1'b1;
  logic       b_ack, b_mux, b_en, b_demux, b_fbwe, b_psv, b_done, b_busy, b_err;
  logic [2:0] b_rot;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_stage_sequencer #(.STAGES(3), .BEATS(2), .BF_LAT(1), .ROT_W(3)) dut_a (
    .clk(clk), .rst(rst), .sp_frame_rdy(a_rdy), .ps_ready(a_psr),
    .sp_ack(a_ack), .mux_flag(a_mux), .bf_en(a_en), .rotation(a_rot),
    .demux_flag(a_demux), .fb_we(a_fbwe), .ps_valid(a_psv),
    .frame_done(a_done), .busy(a_busy), .err_overrun(a_err)
  );

  fft_stage_sequencer #(.STAGES(3), .BEATS(2), .BF_LAT(3), .ROT_W(3)) dut_b (
    .clk(clk), .rst(rst), .sp_frame_rdy(b_rdy), .ps_ready(b_psr),
    .sp_ack(b_ack), .mux_flag(b_mux), .bf_en(b_en), .rotation(b_rot),
    .demux_flag(b_demux), .fb_we(b_fbwe), .ps_valid(b_psv),
    .frame_done(b_done), .busy(b_busy), .err_overrun(b_err)
  );

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Expected trace of one frame from acceptance at cycle t: stage k issues
  // BEATS beats, then waits lat cycles; the last stage may be held off
  // until ps_ready (high from cycle ps_rel) is seen on its entry cycle.
  task automatic push_frame(input int t, input int lat, input int ps_rel, input bit to_b);
    exp_t tr[64];
    int   start;
    int   end_c;
    int   c;
    start = t + 1;
    for (int i = 0; i < 64; i++) begin
      tr[i] = '{cyc: t + i, bf_en: 0, rot: 0, mux: 0, fb_we: 0,
                ps_valid: 0, frame_done: 0, busy: 0, sp_ack: 0};
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 2 && (start - 1) < ps_rel) start = ps_rel + 1;
      for (int b = 0; b < 2; b++) begin
        c = start + b;
        tr[c-t].bf_en = 1'b1;
        tr[c-t].rot   = 3'((b << k) & 7);
        tr[c-t].mux   = (k != 0);
        if (k == 2) tr[c-t+lat].ps_valid = 1'b1;
        else        tr[c-t+lat].fb_we    = 1'b1;
      end
      start = start + 2 + lat;
    end
    end_c = start - 1;
    tr[end_c-t].frame_done = 1'b1;
    tr[1].sp_ack = 1'b1;
    for (int i = 1; i <= end_c - t; i++) tr[i].busy = 1'b1;
    for (int i = 1; i <= end_c - t + 1; i++) begin
      if (to_b) qb.push_back(tr[i]);
      else      qa.push_back(tr[i]);
    end
  endtask

  task automatic cmp(input string p, input exp_t e, input logic en, input logic [2:0] rot,
                     input logic mux, input logic demux, input logic fbwe, input logic psv,
                     input logic done, input logic bsy, input logic ack);
    check_eq({p, "_bf_en"}, int'(en), int'(e.bf_en));
    check_eq({p, "_busy"}, int'(bsy), int'(e.busy));
    check_eq({p, "_sp_ack"}, int'(ack), int'(e.sp_ack));
    check_eq({p, "_fb_we"}, int'(fbwe), int'(e.fb_we));
    check_eq({p, "_ps_valid"}, int'(psv), int'(e.ps_valid));
    check_eq({p, "_frame_done"}, int'(done), int'(e.frame_done));
    if (e.bf_en) begin
      check_eq({p, "_rotation"}, int'(rot), int'(e.rot));
      check_eq({p, "_mux_flag"}, int'(mux), int'(e.mux));
    end else begin
      check_eq({p, "_rotation_idle"}, int'(rot), 0);
    end
    if (e.fb_we || e.ps_valid) check_eq({p, "_demux_flag"}, int'(demux), int'(e.ps_valid));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      e = qa.pop_front();
      cmp("a", e, a_en, a_rot, a_mux, a_demux, a_fbwe, a_psv, a_done, a_busy, a_ack);
    end
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      e = qb.pop_front();
      cmp("b", e, b_en, b_rot, b_mux, b_demux, b_fbwe, b_psv, b_done, b_busy, b_ack);
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_a_quiet(input string tag);
    check_eq({tag, "_busy"}, int'(a_busy), 0);
    check_eq({tag, "_bf_en"}, int'(a_en), 0);
    check_eq({tag, "_sp_ack"}, int'(a_ack), 0);
    check_eq({tag, "_fb_we"}, int'(a_fbwe), 0);
    check_eq({tag, "_ps_valid"}, int'(a_psv), 0);
    check_eq({tag, "_frame_done"}, int'(a_done), 0);
    check_eq({tag, "_demux"}, int'(a_demux), 0);
    check_eq({tag, "_mux"}, int'(a_mux), 0);
    check_eq({tag, "_rotation"}, int'(a_rot), 0);
    check_eq({tag, "_err"}, int'(a_err), 0);
  endtask

  initial begin
    // Reset state
    goto(2);
    @(negedge clk);
    check_a_quiet("rst_a");
    check_eq("rst_b_busy", int'(b_busy), 0);
    check_eq("rst_b_ps_valid", int'(b_psv), 0);
    check_eq("rst_b_err", int'(b_err), 0);
    goto(3);
    rst = 1'b0;

    // Single frame on both latencies
    goto(10);
    a_rdy = 1'b1; b_rdy = 1'b1;
    push_frame(10, 1, 0, 1'b0);
    push_frame(10, 3, 0, 1'b1);
    goto(11);
    a_rdy = 1'b0; b_rdy = 1'b0;

    // Back-to-back: pulse in the first IDLE cycle
    goto(20);
    a_rdy = 1'b1;
    push_frame(20, 1, 0, 1'b0);
    goto(21);
    a_rdy = 1'b0;

    // Serializer not ready until T+15; drops again mid-stage are ignored
    goto(35);
    a_psr = 1'b0;
    goto(40);
    a_rdy = 1'b1;
    push_frame(40, 1, 55, 1'b0);
    goto(41);
    a_rdy = 1'b0;
    goto(55);
    a_psr = 1'b1;
    goto(57);
    a_psr = 1'b0;
    goto(58);
    a_psr = 1'b1;
    goto(60);
    @(negedge clk);
    check_eq("no_overrun", int'(a_err), 0);

    // Overrun pulse mid-frame
    goto(70);
    a_rdy = 1'b1;
    push_frame(70, 1, 0, 1'b0);
    goto(71);
    a_rdy = 1'b0;
    goto(73);
    @(negedge clk);
    check_eq("err_before", int'(a_err), 0);
    goto(74);
    a_rdy = 1'b1;
    goto(75);
    a_rdy = 1'b0;
    @(negedge clk);
    check_eq("err_set", int'(a_err), 1);
    goto(82);
    @(negedge clk);
    check_eq("err_sticky", int'(a_err), 1);
    check_eq("err_idle_busy", int'(a_busy), 0);

    // Reset mid-frame, then a clean frame
    goto(100);
    a_rdy = 1'b1;
    goto(101);
    a_rdy = 1'b0;
    goto(105);
    rst = 1'b1;
    goto(106);
    rst = 1'b0;
    @(negedge clk);
    check_a_quiet("midrst");
    goto(108);
    a_rdy = 1'b1;
    push_frame(108, 1, 0, 1'b0);
    goto(109);
    a_rdy = 1'b0;

    for (int i = 0; i < 300 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
    if (qa.size() > 0 || qb.size() > 0) check_eq("scoreboard_timeout", qa.size() + qb.size(), 0);
    #1;
    check_eq("final_err_b", int'(b_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
